hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit.sv | 192 +++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stall and branch/jump flush control for a
// classic 5-stage pipeline. Outputs are combinational from the inputs and the
// registered FSM state, so a hazard or branch takes effect in the cycle it
// appears. A small down-counter stretches stalls to LOAD_LAT cycles and
// flushes to FLUSH_DEPTH cycles.
// Optional build macro: HAZARD_PERF_EN adds saturating 16-bit Stall_Count and
// Flush_Count performance counters.
module hazard_control_unit #(
  parameter int REG_W       = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             MemRead_signal_EX,
  input  logic [REG_W-1:0] rt_EX,
  input  logic [REG_W-1:0] rs_ID,
  input  logic [REG_W-1:0] rt_ID,
  input  logic             Use_rs_ID,
  input  logic             Use_rt_ID,
  input  logic             Mem_Busy,
  output logic             PCWrite,
  output logic             IF_ID_RegWrite,
  output logic             Stall,
  output logic             Flush,
  output logic [1:0]       Hazard_State
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]      Stall_Count,
  output logic [15:0]      Flush_Count
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    ILLEGAL    = 2'd3
  } state_t;

  // Counter preload values: the first stall/flush cycle happens in IDLE (or
  // on the branch cycle), so the counter covers only the remaining cycles.
  localparam logic [1:0] LOAD_CNT_INIT  = 2'(LOAD_LAT - 1);
  localparam logic [1:0] FLUSH_CNT_INIT = 2'(FLUSH_DEPTH - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic hz;
  logic redirect;
  logic pc_we, ifid_we, stall_int, flush_int;

  // Load-use hazard detect; register 0 is hardwired and never stalls.
  always_comb begin
    hz = MemRead_signal_EX && (rt_EX != '0) &&
         ((Use_rs_ID && (rt_EX == rs_ID)) || (Use_rt_ID && (rt_EX == rt_ID)));
    redirect = Branch | Jump;
  end

  // Next-state and internal control decode, highest priority first.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    stall_int = 1'b0;
    flush_int = 1'b0;

    if (Mem_Busy) begin
      // Freeze: everything holds, events are ignored this cycle.
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      if (state_q == ILLEGAL) begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    end else if (redirect) begin
      // A taken branch/jump wins over any stall in progress.
      flush_int = 1'b1;
      if (FLUSH_DEPTH > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_CNT_INIT;
      end else begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          flush_int = 1'b1;
          // Exit on cnt==1; the <= guard also keeps a stray 0 from wrapping.
          if (cnt_q <= 2'd1) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        LOAD_STALL: begin
          stall_int = 1'b1;
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          if (cnt_q <= 2'd1) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        IDLE: begin
          if (hz) begin
            stall_int = 1'b1;
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            if (LOAD_LAT > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = LOAD_CNT_INIT;
            end
          end
        end
        default: begin
          // Illegal encoding: behave as quiet IDLE and recover next cycle.
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Output stage: while reset is held the pipeline runs freely with no bubbles.
  always_comb begin
    if (!reset) begin
      PCWrite        = 1'b1;
      IF_ID_RegWrite = 1'b1;
      Stall          = 1'b0;
      Flush          = 1'b0;
      Hazard_State   = IDLE;
    end else begin
      PCWrite        = pc_we;
      IF_ID_RegWrite = ifid_we;
      Stall          = stall_int;
      Flush          = flush_int;
      Hazard_State   = state_q;
    end
  end

  // FSM state and cycle counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  // Saturating event counters; Stall/Flush are already 0 while busy, so the
  // counters hold then without extra gating.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (Stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
    if (Flush && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign Stall_Count = stall_count_q;
  assign Flush_Count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Testbench for hazard_control_unit: three instances with different
// LOAD_LAT/FLUSH_DEPTH share one stimulus stream. A directed vector table,
// hand-written corner sequences and random stimulus are checked against a
// remaining-cycles reference model.
module tb_hazard_control_unit;

  logic       clk;
  logic       rst_n, br, jp, busy, mr, urs, urt;
  logic [4:0] rtex, rsid, rtid;

  wire [2:0] d_st, d_pcw, d_ifid, d_fl;
  wire [1:0] d_hs [0:2];
`ifdef HAZARD_PERF_EN
  wire [15:0] d_sc [0:2];
  wire [15:0] d_fc [0:2];
`endif

  int LLv [3] = '{1, 3, 2};
  int FDv [3] = '{1, 2, 3};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      hazard_control_unit #(
        .REG_W(5),
        .LOAD_LAT(gi == 0 ? 1 : (gi == 1 ? 3 : 2)),
        .FLUSH_DEPTH(gi == 0 ? 1 : (gi == 1 ? 2 : 3))
      ) u_dut (
        .clk(clk), .reset(rst_n), .Branch(br), .Jump(jp),
        .MemRead_signal_EX(mr), .rt_EX(rtex), .rs_ID(rsid), .rt_ID(rtid),
        .Use_rs_ID(urs), .Use_rt_ID(urt), .Mem_Busy(busy),
        .PCWrite(d_pcw[gi]), .IF_ID_RegWrite(d_ifid[gi]),
        .Stall(d_st[gi]), .Flush(d_fl[gi]), .Hazard_State(d_hs[gi])
`ifdef HAZARD_PERF_EN
        , .Stall_Count(d_sc[gi]), .Flush_Count(d_fc[gi])
`endif
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: cycles still owed to a stall / flush sequence.
  int srem [3] = '{0, 0, 0};
  int frem [3] = '{0, 0, 0};
  int scnt [3] = '{0, 0, 0};
  int fcnt [3] = '{0, 0, 0};

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  function automatic bit hz_f();
    return mr && (rtex != 0) && ((urs && rtex == rsid) || (urt && rtex == rtid));
  endfunction

  function automatic void model_out(input int i, output bit st, output bit pcw,
                                    output bit ifid, output bit fl, output int hs);
    hs = (frem[i] > 0) ? 2 : ((srem[i] > 0) ? 1 : 0);
    st = 0; pcw = 1; ifid = 1; fl = 0;
    if (!rst_n) hs = 0;
    else if (busy) begin pcw = 0; ifid = 0; end
    else if (br || jp) fl = 1;
    else if (frem[i] > 0) fl = 1;
    else if (srem[i] > 0 || hz_f()) begin st = 1; pcw = 0; ifid = 0; end
  endfunction

  // One clock: optional compare against the model, then advance the model.
  task automatic step(input bit do_chk);
    bit st, pcw, ifid, fl;
    int hs;
    #1;
    if (do_chk) begin
      for (int i = 0; i < 3; i++) begin
        model_out(i, st, pcw, ifid, fl, hs);
        chk("model_stall", i, int'(d_st[i]), int'(st));
        chk("model_pcwrite", i, int'(d_pcw[i]), int'(pcw));
        chk("model_ifid", i, int'(d_ifid[i]), int'(ifid));
        chk("model_flush", i, int'(d_fl[i]), int'(fl));
        chk("model_state", i, int'(d_hs[i]), hs);
`ifdef HAZARD_PERF_EN
        chk("model_stall_count", i, int'(d_sc[i]), scnt[i]);
        chk("model_flush_count", i, int'(d_fc[i]), fcnt[i]);
`endif
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      model_out(i, st, pcw, ifid, fl, hs);
      if (!rst_n) begin
        srem[i] = 0; frem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
      end else begin
        if (st && scnt[i] < 65535) scnt[i]++;
        if (fl && fcnt[i] < 65535) fcnt[i]++;
        if (busy) ;
        else if (br || jp) begin frem[i] = FDv[i] - 1; srem[i] = 0; end
        else if (frem[i] > 0) frem[i]--;
        else if (srem[i] > 0) srem[i]--;
        else if (hz_f()) srem[i] = LLv[i] - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic expect_dut(input string nm, input int i, input bit st, input bit pcw,
                            input bit ifid, input bit fl, input int hs);
    #1;
    chk({nm, "_stall"}, i, int'(d_st[i]), int'(st));
    chk({nm, "_pcwrite"}, i, int'(d_pcw[i]), int'(pcw));
    chk({nm, "_ifid"}, i, int'(d_ifid[i]), int'(ifid));
    chk({nm, "_flush"}, i, int'(d_fl[i]), int'(fl));
    chk({nm, "_state"}, i, int'(d_hs[i]), hs);
  endtask

  task automatic drive(input bit r, input bit b, input bit j, input bit bz, input bit m,
                       input logic [4:0] te, input logic [4:0] si, input logic [4:0] ti,
                       input bit us, input bit ut);
    rst_n = r; br = b; jp = j; busy = bz; mr = m;
    rtex = te; rsid = si; rtid = ti; urs = us; urt = ut;
  endtask

  typedef struct {
    bit         rst_n, br, jp, busy, mr;
    logic [4:0] rtex, rsid, rtid;
    bit         urs, urt;
    bit         e_st, e_pcw, e_ifid, e_fl;
    int         e_hs;
  } vec_t;

  vec_t tbl [21];

  initial begin
    // Expected columns refer to dut1 (LOAD_LAT=3, FLUSH_DEPTH=2).
    tbl[0]  = '{0,0,0,0,0, 0,0,0, 0,0, 0,1,1,0,0};  // in reset
    tbl[1]  = '{1,0,0,0,0, 0,0,0, 0,0, 0,1,1,0,0};  // idle
    tbl[2]  = '{1,0,0,0,1, 5,5,0, 1,0, 1,0,0,0,0};  // lw r5 -> use rs r5
    tbl[3]  = '{1,0,0,0,1, 5,5,0, 1,0, 1,0,0,0,1};
    tbl[4]  = '{1,0,0,0,1, 5,5,0, 1,0, 1,0,0,0,1};
    tbl[5]  = '{1,0,0,0,0, 0,0,0, 0,0, 0,1,1,0,0};  // exactly three stalls
    tbl[6]  = '{1,0,0,0,1, 0,0,0, 1,0, 0,1,1,0,0};  // r0 never stalls
    tbl[7]  = '{1,0,0,0,1, 7,3,7, 1,0, 0,1,1,0,0};  // rt match but unused
    tbl[8]  = '{1,0,0,0,1, 7,3,7, 0,1, 1,0,0,0,0};  // rt match used
    tbl[9]  = '{1,1,0,0,0, 0,0,0, 0,0, 0,1,1,1,1};  // branch in 2nd stall cycle
    tbl[10] = '{1,0,0,0,0, 0,0,0, 0,0, 0,1,1,1,2};
    tbl[11] = '{1,0,0,0,0, 0,0,0, 0,0, 0,1,1,0,0};
    tbl[12] = '{1,0,1,0,1, 5,5,0, 1,0, 0,1,1,1,0};  // jump beats hazard
    tbl[13] = '{1,0,0,0,1, 5,5,0, 1,0, 0,1,1,1,2};  // hazard masked in FLUSH
    tbl[14] = '{1,0,0,0,1, 5,5,0, 1,0, 1,0,0,0,0};
    tbl[15] = '{1,0,0,1,1, 5,5,0, 1,0, 0,0,0,0,1};  // busy freezes stall
    tbl[16] = '{1,0,0,0,0, 0,0,0, 0,0, 1,0,0,0,1};
    tbl[17] = '{1,0,0,0,0, 0,0,0, 0,0, 1,0,0,0,1};
    tbl[18] = '{1,0,0,0,0, 0,0,0, 0,0, 0,1,1,0,0};
    tbl[19] = '{1,1,0,1,0, 0,0,0, 0,0, 0,0,0,0,0};  // busy masks branch
    tbl[20] = '{1,0,0,0,0, 0,0,0, 0,0, 0,1,1,0,0};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step(0);
    step(0);

    for (int v = 0; v < 21; v++) begin
      drive(tbl[v].rst_n, tbl[v].br, tbl[v].jp, tbl[v].busy, tbl[v].mr,
            tbl[v].rtex, tbl[v].rsid, tbl[v].rtid, tbl[v].urs, tbl[v].urt);
      expect_dut($sformatf("vec%0d", v), 1, tbl[v].e_st, tbl[v].e_pcw,
                 tbl[v].e_ifid, tbl[v].e_fl, tbl[v].e_hs);
      step(1);
      $display("vec %0d: st=%0d pc=%0d fl=%0d hs=%0d", v, d_st[1], d_pcw[1], d_fl[1], d_hs[1]);
    end

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1);

    // Busy for four cycles in the middle of a LOAD_LAT=2 stall (dut2).
    drive(1, 0, 0, 0, 1, 9, 9, 0, 1, 0);
    expect_dut("busy_start", 2, 1, 0, 0, 0, 0);
    step(1);
    drive(1, 0, 0, 1, 1, 9, 9, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      expect_dut("busy_hold", 2, 0, 0, 0, 0, 1);
      step(1);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_dut("busy_resume", 2, 1, 0, 0, 0, 1);
    step(1);
    expect_dut("busy_done", 2, 0, 1, 1, 0, 0);
    step(1);
    $display("seq busy_mid_stall done");

    // Reset during a FLUSH_DEPTH=3 flush (dut2).
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_dut("rflush_br", 2, 0, 1, 1, 1, 0);
    step(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_dut("rflush_mid", 2, 0, 1, 1, 1, 2);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_dut("rflush_rst", 2, 0, 1, 1, 0, 0);
    step(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_dut("rflush_after", 2, 0, 1, 1, 0, 0);
    step(1);
    $display("seq reset_mid_flush done");

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      step(1);
    end
    $display("random phase done: errors so far %0d", n_err);

`ifdef HAZARD_PERF_EN
    // Continuous hazard for 70000 cycles saturates the stall counter.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0);
    drive(1, 0, 0, 0, 1, 5, 5, 0, 1, 0);
    for (int k = 0; k < 70000; k++) step(0);
    #1;
    chk("stall_count_sat", 1, int'(d_sc[1]), 16'hFFFF);
    chk("stall_count_sat", 0, int'(d_sc[0]), 16'hFFFF);
    step(1);
    $display("seq stall_count_saturation: count=%0h", d_sc[1]);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
